// File: rtl/odd_result_chain_if.sv
// Issue bus into the result chain: one result per cycle,
// in_valid/in_wrt_en qualify in_rt_addr/in_value/in_lat.
interface odd_result_chain_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128,
  parameter int LAT_W  = 3
);
  logic              in_valid;
  logic              in_wrt_en;
  logic [ADDR_W-1:0] in_rt_addr;
  logic [DATA_W-1:0] in_value;
  logic [LAT_W-1:0]  in_lat;

  modport master (
    output in_valid, in_wrt_en, in_rt_addr,
    output in_value, in_lat
  );

  modport slave (
    input in_valid, in_wrt_en, in_rt_addr,
    input in_value, in_lat
  );
endinterface

// File: rtl/odd_result_chain.sv
// Result/forwarding chain: issue -> stage 1..DEPTH -> writeback.
// Ports: clock/reset, issue bus, flush, rd_addr -> fw_*, stage_bus, wb_*.
module odd_result_chain #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7,
  parameter int DEPTH      = 7,
  parameter int NUM_RD     = 3,
  parameter int KILL_DEPTH = 2,
  parameter int LAT_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  odd_result_chain_if.slave          issue,
  input  logic                       flush,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          fw_hit,
  output logic [NUM_RD-1:0]          fw_pending,
  output logic [NUM_RD*DATA_W-1:0]   fw_data,
  output logic [DEPTH*(2+ADDR_W+DATA_W)-1:0] stage_bus,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_value
);

  localparam int SW = 2 + ADDR_W + DATA_W;

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  wen_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [LAT_W-1:0]  lat_q  [DEPTH];
  logic [DEPTH-1:0]  rdy;

  logic              take;
  logic [LAT_W-1:0]  lat_c;

  assign take = issue.in_valid & issue.in_wrt_en & ~flush;

  always_comb begin
    lat_c = issue.in_lat;
    if (issue.in_lat == '0)
      lat_c = LAT_W'(1);
    else if (issue.in_lat > LAT_W'(DEPTH))
      lat_c = LAT_W'(DEPTH);
  end

  // Index i holds stage i+1; a flush kills what would
  // land in stages 2..KILL_DEPTH (stage 1 is a bubble anyway).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      wen_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        val_q[i]  <= '0;
        lat_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= take;
      wen_q[0]  <= take;
      addr_q[0] <= take ? issue.in_rt_addr : '0;
      val_q[0]  <= take ? issue.in_value : '0;
      lat_q[0]  <= take ? lat_c : '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (flush && i < KILL_DEPTH) begin
          vld_q[i]  <= 1'b0;
          wen_q[i]  <= 1'b0;
          addr_q[i] <= '0;
          val_q[i]  <= '0;
          lat_q[i]  <= '0;
        end else begin
          vld_q[i]  <= vld_q[i-1];
          wen_q[i]  <= wen_q[i-1];
          addr_q[i] <= addr_q[i-1];
          val_q[i]  <= val_q[i-1];
          lat_q[i]  <= lat_q[i-1];
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = vld_q[i] && ((i + 1) >= int'(lat_q[i]));
  end

  // Scan oldest to youngest so the youngest match
  // overwrites: a stale older copy is never forwarded.
  always_comb begin
    fw_hit     = '0;
    fw_pending = '0;
    fw_data    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (vld_q[s] &&
            addr_q[s] == rd_addr[k*ADDR_W +: ADDR_W]) begin
          fw_hit[k]     = rdy[s];
          fw_pending[k] = !rdy[s];
          fw_data[k*DATA_W +: DATA_W] =
            rdy[s] ? val_q[s] : '0;
        end
      end
    end
  end

  always_comb begin
    stage_bus = '0;
    for (int s = 0; s < DEPTH; s++)
      stage_bus[s*SW +: SW] =
        {vld_q[s], rdy[s], addr_q[s], val_q[s]};
  end

  assign wb_en    = vld_q[DEPTH-1] & wen_q[DEPTH-1];
  assign wb_addr  = addr_q[DEPTH-1];
  assign wb_value = val_q[DEPTH-1];

endmodule

// File: tb/tb_odd_result_chain.sv
// Bench for odd_result_chain: queue model + negedge monitor,
// plus DEPTH=2 and DEPTH=10 instances for latency/clamp.
module tb_odd_result_chain;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 7;
  localparam int NUM_RD = 3;
  localparam int KILL   = 2;
  localparam int LAT_W  = 3;
  localparam int SW     = 2 + ADDR_W + DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  odd_result_chain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LAT_W(LAT_W)) bus ();
  logic                     flush;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        fw_hit, fw_pending;
  logic [NUM_RD*DATA_W-1:0] fw_data;
  logic [DEPTH*SW-1:0]      stage_bus;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_value;

  odd_result_chain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .NUM_RD(NUM_RD), .KILL_DEPTH(KILL),
    .LAT_W(LAT_W)) dut (
    .clock(clock), .reset(reset), .issue(bus),
    .flush(flush), .rd_addr(rd_addr), .fw_hit(fw_hit),
    .fw_pending(fw_pending), .fw_data(fw_data),
    .stage_bus(stage_bus), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_value(wb_value));

  odd_result_chain_if #(.ADDR_W(7), .DATA_W(128), .LAT_W(2)) bus2 ();
  logic          flush2;
  logic [20:0]   rd2;
  logic [2:0]    hit2, pend2;
  logic [383:0]  data2;
  logic [2*SW-1:0] sb2;
  logic          wb2;
  logic [6:0]    wa2;
  logic [127:0]  wv2;

  odd_result_chain #(.DEPTH(2), .KILL_DEPTH(1), .NUM_RD(3),
    .LAT_W(2)) u2 (
    .clock(clock), .reset(reset), .issue(bus2),
    .flush(flush2), .rd_addr(rd2), .fw_hit(hit2),
    .fw_pending(pend2), .fw_data(data2), .stage_bus(sb2),
    .wb_en(wb2), .wb_addr(wa2), .wb_value(wv2));

  odd_result_chain_if #(.ADDR_W(7), .DATA_W(128), .LAT_W(4)) bus10 ();
  logic          flush10;
  logic [6:0]    rd10;
  logic          hit10, pend10;
  logic [127:0]  data10;
  logic [10*SW-1:0] sb10;
  logic          wb10;
  logic [6:0]    wa10;
  logic [127:0]  wv10;

  odd_result_chain #(.DEPTH(10), .KILL_DEPTH(2), .NUM_RD(1),
    .LAT_W(4)) u10 (
    .clock(clock), .reset(reset), .issue(bus10),
    .flush(flush10), .rd_addr(rd10), .fw_hit(hit10),
    .fw_pending(pend10), .fw_data(data10), .stage_bus(sb10),
    .wb_en(wb10), .wb_addr(wa10), .wb_value(wv10));

  typedef struct {
    logic [6:0]   addr;
    logic [127:0] value;
    int           lat;
    int           age;
  } ent_t;

  ent_t fl[$];
  int   compared = 0;
  int   mismatched = 0;
  int   wb_seen [128];
  bit   run = 1'b0;
  logic any_v;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each in-flight result is tracked by its age (= stage it
  // occupies); it retires once its age reaches DEPTH.
  function automatic void model_edge();
    ent_t e;
    ent_t nq[$];
    foreach (fl[i]) begin
      e = fl[i];
      e.age++;
      if (e.age > DEPTH) continue;
      if (flush && e.age >= 2 && e.age <= KILL) continue;
      nq.push_back(e);
    end
    if (bus.in_valid && bus.in_wrt_en && !flush) begin
      e.addr  = bus.in_rt_addr;
      e.value = bus.in_value;
      e.lat   = int'(bus.in_lat);
      if (e.lat < 1) e.lat = 1;
      if (e.lat > DEPTH) e.lat = DEPTH;
      e.age   = 1;
      nq.push_back(e);
    end
    fl = nq;
  endfunction

  function automatic void lookup(input logic [6:0] a,
    output logic h, output logic p, output logic [127:0] d);
    int b;
    b = -1;
    foreach (fl[i])
      if (fl[i].addr == a && (b < 0 || fl[i].age < fl[b].age))
        b = i;
    h = 1'b0;
    p = 1'b0;
    d = '0;
    if (b >= 0) begin
      if (fl[b].age >= fl[b].lat) begin
        h = 1'b1;
        d = fl[b].value;
      end else begin
        p = 1'b1;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (run && reset) begin
      logic h, p;
      logic [127:0] d;
      bit exp_wb;
      for (int k = 0; k < NUM_RD; k++) begin
        lookup(rd_addr[k*ADDR_W +: ADDR_W], h, p, d);
        chk($sformatf("fw_hit[%0d]", k), fw_hit[k], h);
        chk($sformatf("fw_pending[%0d]", k), fw_pending[k], p);
        chk($sformatf("fw_data[%0d]", k),
            fw_data[k*DATA_W +: DATA_W], d);
      end
      exp_wb = fl.size() > 0 && fl[0].age == DEPTH;
      chk("wb_en", wb_en, exp_wb);
      if (wb_en) wb_seen[wb_addr]++;
      if (exp_wb) begin
        chk("wb_addr", wb_addr, fl[0].addr);
        chk("wb_value", wb_value, fl[0].value);
        void'(fl.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_issue(bit v, bit w, logic [6:0] a,
    logic [127:0] val, logic [2:0] lat, bit f);
    bus.in_valid   = v;
    bus.in_wrt_en  = w;
    bus.in_rt_addr = a;
    bus.in_value   = val;
    bus.in_lat     = lat;
    flush          = f;
  endtask

  task automatic idle(int n);
    set_issue(0, 0, 7'd0, '0, 3'd0, 0);
    repeat (n) next_cycle();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    foreach (wb_seen[i]) wb_seen[i] = 0;
    set_issue(0, 0, 7'd0, '0, 3'd0, 0);
    rd_addr = '0;
    bus2.in_valid = 0; bus2.in_wrt_en = 0;
    bus2.in_rt_addr = '0; bus2.in_value = '0; bus2.in_lat = '0;
    bus10.in_valid = 0; bus10.in_wrt_en = 0;
    bus10.in_rt_addr = '0; bus10.in_value = '0; bus10.in_lat = '0;
    flush2 = 0; rd2 = '0; flush10 = 0; rd10 = '0;

    #12;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_fw_hit", fw_hit, 0);
    chk("rst_fw_pending", fw_pending, 0);
    chk("rst_fw_data_or", |fw_data, 0);
    chk("rst_stage_bus_or", |stage_bus, 0);
    #1 reset = 1'b1;
    run = 1'b1;

    // latency on all three chains; u2/u10 lat clamped to DEPTH
    set_issue(1, 1, 7'd5, 128'h2A, 3'd4, 0);
    rd_addr = {7'd0, 7'd0, 7'd5};
    bus2.in_valid = 1; bus2.in_wrt_en = 1;
    bus2.in_rt_addr = 7'h11; bus2.in_value = 128'h77;
    bus2.in_lat = 2'd3;
    rd2 = {7'd0, 7'd0, 7'h11};
    bus10.in_valid = 1; bus10.in_wrt_en = 1;
    bus10.in_rt_addr = 7'h11; bus10.in_value = 128'h99;
    bus10.in_lat = 4'd15;
    rd10 = 7'h11;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 1) begin
        set_issue(0, 0, 7'd0, '0, 3'd0, 0);
        bus2.in_valid = 0;
        bus10.in_valid = 0;
      end
      chk("lat_pending", fw_pending[0], c < 4);
      chk("lat_hit", fw_hit[0], c >= 4 && c <= 7);
      chk("lat_wb_en", wb_en, c == 7);
      if (c == 4) chk("lat_data", fw_data[127:0], 128'h2A);
      if (c == 7) chk("lat_wb_addr", wb_addr, 7'd5);
      chk("d2_wb_en", wb2, c == 2);
      chk("d2_hit", hit2[0], c == 2);
      chk("d2_pending", pend2[0], c < 2);
      chk("d10_wb_en", wb10, c == 10);
      chk("d10_hit", hit10, c == 10);
      chk("d10_pending", pend10, c < 10);
      if (c == 10) chk("d10_wb_value", wv10, 128'h99);
    end

    // youngest match decides
    idle(2);
    rd_addr = {7'd9, 7'd9, 7'd9};
    set_issue(1, 1, 7'd9, 128'd1, 3'd1, 0);
    next_cycle();
    chk("yw_c1_hit", fw_hit[0], 1);
    chk("yw_c1_data", fw_data[127:0], 128'd1);
    set_issue(1, 1, 7'd9, 128'd2, 3'd3, 0);
    next_cycle();
    set_issue(0, 0, 7'd0, '0, 3'd0, 0);
    chk("yw_c2_pending", fw_pending[0], 1);
    chk("yw_c2_hit", fw_hit[0], 0);
    next_cycle();
    chk("yw_c3_pending", fw_pending[1], 1);
    next_cycle();
    chk("yw_c4_hit", fw_hit[2], 1);
    chk("yw_c4_data", fw_data[383:256], 128'd2);
    idle(8);

    // flush: A, B, C (flushed), D (flushed)
    rd_addr = {7'h23, 7'h22, 7'h21};
    set_issue(1, 1, 7'h21, rnd128(), 3'd2, 0);
    next_cycle();
    set_issue(1, 1, 7'h22, rnd128(), 3'd1, 0);
    next_cycle();
    set_issue(1, 1, 7'h23, rnd128(), 3'd1, 1);
    next_cycle();
    set_issue(1, 1, 7'h24, rnd128(), 3'd1, 1);
    next_cycle();
    idle(12);
    chk("flush_A_retired", wb_seen[7'h21], 1);
    chk("flush_B_killed", wb_seen[7'h22], 0);
    chk("flush_C_dropped", wb_seen[7'h23], 0);
    chk("flush_D_dropped", wb_seen[7'h24], 0);

    // non-writing ops never enter
    rd_addr = {7'h30, 7'h30, 7'h30};
    for (int c = 0; c < 3; c++) begin
      set_issue(1, 0, 7'h30, rnd128(), 3'd1, 0);
      next_cycle();
    end
    set_issue(0, 0, 7'd0, '0, 3'd0, 0);
    for (int c = 0; c <= DEPTH; c++) begin
      any_v = 1'b0;
      for (int s = 0; s < DEPTH; s++)
        any_v |= stage_bus[s*SW + SW - 1];
      chk("nowrite_valid", any_v, 0);
      next_cycle();
    end
    chk("nowrite_wb", wb_seen[7'h30], 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_issue($urandom_range(0, 9) < 6,
                $urandom_range(0, 3) != 0,
                7'($urandom_range(0, 7)), rnd128(),
                3'($urandom_range(0, 7)),
                $urandom_range(0, 9) == 0);
      for (int k = 0; k < NUM_RD; k++)
        rd_addr[k*ADDR_W +: ADDR_W] = 7'($urandom_range(0, 7));
      next_cycle();
    end
    idle(10);

    // reset mid-stream with three results in flight
    rd_addr = {7'h42, 7'h41, 7'h40};
    for (int c = 0; c < 3; c++) begin
      set_issue(1, 1, 7'(7'h40 + c), rnd128(), 3'd1, 0);
      next_cycle();
    end
    set_issue(0, 0, 7'd0, '0, 3'd0, 0);
    chk("pre_rst_inflight", fw_hit, 3'b111);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_wb_en", wb_en, 0);
    chk("mid_rst_fw_hit", fw_hit, 0);
    chk("mid_rst_fw_pending", fw_pending, 0);
    chk("mid_rst_fw_data_or", |fw_data, 0);
    chk("mid_rst_stage_bus_or", |stage_bus, 0);
    fl.delete();
    reset = 1'b1;
    idle(12);
    chk("rst_no_wb_40", wb_seen[7'h40], 0);
    chk("rst_no_wb_41", wb_seen[7'h41], 0);
    chk("rst_no_wb_42", wb_seen[7'h42], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
